// File: rtl/simple_exec_seq.sv
// Execution sequencer for the SIMPLE multi-cycle core.
// Generates one-hot phase strobes, handles run/single-step control,
// memory wait-state stretching with timeout, a PC breakpoint and a
// retired-instruction counter. All outputs come straight from flops.
module simple_exec_seq #(
    parameter int NPHASE   = 5,
    parameter int PC_W     = 16,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_mode_i,
    input  logic              exec_pulse_i,
    input  logic              halt_req_i,
    input  logic              mem_wait_i,
    input  logic              bp_en_i,
    input  logic [PC_W-1:0]   bp_addr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [NPHASE-1:0] phase_o,
    output logic [3:0]        phase_idx_o,
    output logic              instr_done_o,
    output logic              running_o,
    output logic              halted_o,
    output logic              bp_hit_o,
    output logic              timeout_err_o,
    output logic [CNT_W-1:0]  instr_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int                LAST        = NPHASE - 1;
    localparam logic [NPHASE-1:0] PHASE_FIRST = {{(NPHASE-1){1'b0}}, 1'b1};
    localparam logic [NPHASE-1:0] PHASE_NONE  = {NPHASE{1'b0}};
    localparam logic [7:0]        WAIT_LIM    = 8'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [NPHASE-1:0]   phase_q, phase_d;
    logic [3:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic                running_q, running_d;
    logic                halted_q, halted_d;
    logic                bp_hit_q, bp_hit_d;
    logic                to_q, to_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halt_lat_q, halt_lat_d;
    logic                stop_lat_q, stop_lat_d;
    logic [7:0]          wait_q, wait_d;

    logic                halt_eff_s;
    logic                stop_eff_s;
    logic                bp_match_s;
    logic [7:0]          wait_inc_s;
    logic [NPHASE-1:0]   phase_rot_s;

    // Requests that arrive in the boundary cycle itself count for that boundary.
    always_comb begin
        halt_eff_s  = halt_lat_q | halt_req_i;
        stop_eff_s  = stop_lat_q | (exec_pulse_i & run_mode_i);
        bp_match_s  = bp_en_i & (pc_i == bp_addr_i);
        wait_inc_s  = (state_q == S_STALL) ? (wait_q + 8'd1) : 8'd1;
        phase_rot_s = {phase_q[NPHASE-2:0], phase_q[LAST]};
    end

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        running_d  = running_q;
        halted_d   = halted_q;
        bp_hit_d   = bp_hit_q;
        to_d       = to_q;
        cnt_d      = cnt_q;
        halt_lat_d = halt_lat_q;
        stop_lat_d = stop_lat_q;
        wait_d     = wait_q;

        case (state_q)
            S_IDLE: begin
                if (exec_pulse_i) begin
                    state_d    = S_RUN;
                    phase_d    = PHASE_FIRST;
                    idx_d      = 4'd0;
                    running_d  = 1'b1;
                    bp_hit_d   = 1'b0;
                    to_d       = 1'b0;
                    halt_lat_d = 1'b0;
                    stop_lat_d = 1'b0;
                    wait_d     = 8'd0;
                end else begin
                    phase_d   = PHASE_NONE;
                    idx_d     = 4'd0;
                    running_d = 1'b0;
                end
            end

            S_RUN, S_STALL: begin
                if (halt_req_i) begin
                    halt_lat_d = 1'b1;
                end else begin
                    halt_lat_d = halt_lat_q;
                end
                if (exec_pulse_i && run_mode_i) begin
                    stop_lat_d = 1'b1;
                end else begin
                    stop_lat_d = stop_lat_q;
                end

                if (mem_wait_i) begin
                    if (wait_inc_s >= WAIT_LIM) begin
                        // Memory never answered: abandon the instruction.
                        state_d    = S_HALT;
                        phase_d    = PHASE_NONE;
                        idx_d      = 4'd0;
                        running_d  = 1'b0;
                        halted_d   = 1'b1;
                        to_d       = 1'b1;
                        wait_d     = 8'd0;
                        halt_lat_d = 1'b0;
                        stop_lat_d = 1'b0;
                    end else begin
                        state_d = S_STALL;
                        wait_d  = wait_inc_s;
                    end
                end else begin
                    state_d = S_RUN;
                    wait_d  = 8'd0;
                    if (phase_q[LAST]) begin
                        // Instruction boundary: retire and choose what comes next.
                        done_d     = 1'b1;
                        cnt_d      = cnt_q + CNT_ONE;
                        halt_lat_d = 1'b0;
                        stop_lat_d = 1'b0;
                        if (halt_eff_s) begin
                            state_d   = S_HALT;
                            phase_d   = PHASE_NONE;
                            idx_d     = 4'd0;
                            running_d = 1'b0;
                            halted_d  = 1'b1;
                        end else if (bp_match_s) begin
                            state_d   = S_IDLE;
                            phase_d   = PHASE_NONE;
                            idx_d     = 4'd0;
                            running_d = 1'b0;
                            bp_hit_d  = 1'b1;
                        end else if (stop_eff_s || !run_mode_i) begin
                            state_d   = S_IDLE;
                            phase_d   = PHASE_NONE;
                            idx_d     = 4'd0;
                            running_d = 1'b0;
                        end else begin
                            phase_d = PHASE_FIRST;
                            idx_d   = 4'd0;
                        end
                    end else begin
                        phase_d = phase_rot_s;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end

            S_HALT: begin
                phase_d   = PHASE_NONE;
                idx_d     = 4'd0;
                running_d = 1'b0;
                halted_d  = 1'b1;
            end

            default: begin
                state_d   = S_IDLE;
                phase_d   = PHASE_NONE;
                idx_d     = 4'd0;
                running_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            phase_q    <= PHASE_NONE;
            idx_q      <= 4'd0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            bp_hit_q   <= 1'b0;
            to_q       <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            halt_lat_q <= 1'b0;
            stop_lat_q <= 1'b0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
            bp_hit_q   <= bp_hit_d;
            to_q       <= to_d;
            cnt_q      <= cnt_d;
            halt_lat_q <= halt_lat_d;
            stop_lat_q <= stop_lat_d;
            wait_q     <= wait_d;
        end
    end

    assign phase_o       = phase_q;
    assign phase_idx_o   = idx_q;
    assign instr_done_o  = done_q;
    assign running_o     = running_q;
    assign halted_o      = halted_q;
    assign bp_hit_o      = bp_hit_q;
    assign timeout_err_o = to_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_simple_exec_seq.sv
// Self-checking bench for simple_exec_seq (NPHASE=5, WAIT_MAX=15).
module tb_simple_exec_seq;

    localparam int NP = 5;
    localparam int PW = 16;
    localparam int WM = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_mode = 1'b0;
    logic          exec_pulse = 1'b0;
    logic          halt_req = 1'b0;
    logic          mem_wait = 1'b0;
    logic          bp_en = 1'b0;
    logic [PW-1:0] bp_addr = 16'd0;
    logic [PW-1:0] pc = 16'd0;
    logic [NP-1:0] phase;
    logic [3:0]    phase_idx;
    logic          instr_done, running, halted, bp_hit, timeout_err;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int failures = 0;
    int cnt = 0;

    simple_exec_seq #(.NPHASE(NP), .PC_W(PW), .WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .run_mode_i    (run_mode),
        .exec_pulse_i  (exec_pulse),
        .halt_req_i    (halt_req),
        .mem_wait_i    (mem_wait),
        .bp_en_i       (bp_en),
        .bp_addr_i     (bp_addr),
        .pc_i          (pc),
        .phase_o       (phase),
        .phase_idx_o   (phase_idx),
        .instr_done_o  (instr_done),
        .running_o     (running),
        .halted_o      (halted),
        .bp_hit_o      (bp_hit),
        .timeout_err_o (timeout_err),
        .instr_count_o (instr_count)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected after the next edge.
    // pk is the active phase number, -1 when no phase strobe is expected.
    typedef struct {
        logic          rm, ex, hr, mw;
        logic [PW-1:0] pc;
        int            pk;
        logic          dn, rn, hl, bh, to;
        logic [CW-1:0] cnt;
    } vec_t;

    logic [29:0] sb_q[$];
    vec_t        tbl [0:17];

    function automatic vec_t mk(input logic rm, input logic ex, input logic hr,
                                input logic mw, input logic [PW-1:0] p, input int pk,
                                input logic dn, input logic rn, input logic hl,
                                input logic bh, input logic to, input int c);
        vec_t v;
        v.rm = rm; v.ex = ex; v.hr = hr; v.mw = mw; v.pc = p; v.pk = pk;
        v.dn = dn; v.rn = rn; v.hl = hl; v.bh = bh; v.to = to; v.cnt = CW'(c);
        return v;
    endfunction

    function automatic logic [29:0] pack_exp(input vec_t v);
        logic [NP-1:0] ph;
        logic [3:0]    ix;
        logic [NP-1:0] one;
        one = 5'd1;
        ph  = (v.pk < 0) ? 5'd0 : (one << v.pk);
        ix  = (v.pk < 0) ? 4'd0 : 4'(v.pk);
        return {ph, ix, v.dn, v.rn, v.hl, v.bh, v.to, v.cnt};
    endfunction

    function automatic logic [29:0] act_vec();
        return {phase, phase_idx, instr_done, running, halted, bp_hit, timeout_err, instr_count};
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [29:0] e;
        logic [29:0] a;
        run_mode   = v.rm;
        exec_pulse = v.ex;
        halt_req   = v.hr;
        mem_wait   = v.mw;
        pc         = v.pc;
        sb_q.push_back(pack_exp(v));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        a = act_vec();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got ph=%b idx=%0d dn=%b rn=%b hl=%b bh=%b to=%b cnt=%0d, want ph=%b idx=%0d dn=%b rn=%b hl=%b bh=%b to=%b cnt=%0d",
                     name, a[29:25], a[24:21], a[20], a[19], a[18], a[17], a[16], a[15:0],
                     e[29:25], e[24:21], e[20], e[19], e[18], e[17], e[16], e[15:0]);
        end
    endtask

    task automatic check_zero(input string name);
        logic [29:0] a;
        a = act_vec();
        checks++;
        if (a !== 30'd0) begin
            failures++;
            $display("FAIL %s: got outputs %h, want all zero", name, a);
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        exec_pulse = 1'b0; halt_req = 1'b0; mem_wait = 1'b0;
        #1;
        check_zero(name);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
    endtask

    // Phases 1..4 of a running instruction; ex/hr pulsed while phase k-1 is visible.
    task automatic body(input logic rm, input int ex_k, input int hr_k,
                        input logic [PW-1:0] p, input string name);
        for (int k = 1; k <= 4; k++) begin
            apply(mk(rm, 1'(k == ex_k), 1'(k == hr_k), 1'b0, p, k, 0, 1, 0, 0, 0, cnt),
                  $sformatf("%s_ph%0d", name, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single step, then a run with a 3-cycle stall at phase 1 stopped at the boundary.
        tbl[0]  = mk(0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1);
        tbl[13] = mk(1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 0, 0, 0, -1, 1, 0, 0, 0, 0, 2);
        tbl[17] = mk(1, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 2);

        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end
        cnt = 2;

        // Continuous run, stop requested during phase 2 of the third instruction.
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, cnt), "run_start");
        for (int i = 1; i <= 3; i++) begin
            body(1'b1, (i == 3) ? 3 : 0, 0, PW'(i - 1), $sformatf("run_i%0d", i));
            cnt++;
            apply(mk(1, 0, 0, 0, PW'(i), (i < 3) ? 0 : -1, 1, 1'(i < 3), 0, 0, 0, cnt),
                  $sformatf("run_bnd%0d", i));
        end
        apply(mk(1, 0, 0, 0, 16'd3, -1, 0, 0, 0, 0, 0, cnt), "run_stopped");

        // mem_wait held 20 cycles: timeout on the 15th wait cycle, then stuck in HALT.
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, cnt), "to_start");
        for (int j = 1; j <= 20; j++) begin
            if (j < WM) apply(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, cnt), $sformatf("to_wait%0d", j));
            else        apply(mk(1, 0, 0, 1, 0, -1, 0, 0, 1, 0, 1, cnt), $sformatf("to_wait%0d", j));
        end
        apply(mk(1, 1, 0, 0, 0, -1, 0, 0, 1, 0, 1, cnt), "to_exec_ignored");
        apply(mk(0, 1, 0, 0, 0, -1, 0, 0, 1, 0, 1, cnt), "to_step_ignored");
        do_reset("reset_after_halt");

        // Breakpoint at 3: stops after the instruction that sets pc=3.
        bp_en = 1'b1;
        bp_addr = 16'd3;
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, cnt), "bp_start");
        for (int i = 0; i < 3; i++) begin
            body(1'b1, 0, 0, PW'(i), $sformatf("bp_i%0d", i));
            cnt++;
            apply(mk(1, 0, 0, 0, PW'(i + 1), (i < 2) ? 0 : -1, 1, 1'(i < 2), 0, 1'(i == 2), 0, cnt),
                  $sformatf("bp_bnd%0d", i));
        end
        apply(mk(1, 0, 0, 0, 16'd3, -1, 0, 0, 0, 1, 0, cnt), "bp_hold");
        // Resume: the branch-to-self at 3 hits the breakpoint again.
        apply(mk(1, 1, 0, 0, 16'd3, 0, 0, 1, 0, 0, 0, cnt), "bp_resume1");
        body(1'b1, 0, 0, 16'd3, "bp_self");
        cnt++;
        apply(mk(1, 0, 0, 0, 16'd3, -1, 1, 0, 0, 1, 0, cnt), "bp_self_bnd");
        // Resume: this time it falls through to 4, then an exec at the boundary stops it.
        apply(mk(1, 1, 0, 0, 16'd3, 0, 0, 1, 0, 0, 0, cnt), "bp_resume2");
        body(1'b1, 0, 0, 16'd3, "bp_fall");
        cnt++;
        apply(mk(1, 0, 0, 0, 16'd4, 0, 1, 1, 0, 0, 0, cnt), "bp_fall_bnd");
        body(1'b1, 0, 0, 16'd4, "bp_next");
        cnt++;
        apply(mk(1, 1, 0, 0, 16'd5, -1, 1, 0, 0, 0, 0, cnt), "bp_exec_bnd");

        // halt_req in phase 2 with pc==bp_addr at the boundary: HALT wins.
        apply(mk(1, 1, 0, 0, 16'd2, 0, 0, 1, 0, 0, 0, cnt), "hb_start");
        body(1'b1, 0, 3, 16'd2, "hb");
        cnt++;
        apply(mk(1, 0, 0, 0, 16'd3, -1, 1, 0, 1, 0, 0, cnt), "hb_bnd");
        apply(mk(1, 1, 0, 0, 16'd3, -1, 0, 0, 1, 0, 0, cnt), "hb_hold");
        do_reset("reset_after_hb");

        // Asynchronous reset in the middle of phase 3.
        bp_en = 1'b0;
        apply(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "ar_start");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "ar_ph1");
        apply(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0), "ar_ph2");
        apply(mk(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0), "ar_ph3");
        #2;
        do_reset("async_reset_mid_phase");
        apply(mk(0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0), "ar_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
